// File: rtl/tpu_result_drain.sv
// tpu_result_drain: reads a contiguous run of partial-sum words from the results
// SRAM and streams them out one lane per beat over a valid/ready interface.
// Optional build macro: RESULT_RELU_EN clamps negative lanes to zero before
// sign extension; control, timing and handshake are unchanged.
module tpu_result_drain #(
  parameter int ADDRESSSIZE    = 10,
  parameter int PARTIAL_SUM_BW = 20,
  parameter int MATRIX_SIZE    = 8,
  parameter int OUT_BW         = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [ADDRESSSIZE-1:0]                base_addr,
  input  logic [ADDRESSSIZE:0]                  num_words,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  sram_rd_en,
  output logic [ADDRESSSIZE-1:0]                sram_rd_addr,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_rd_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [OUT_BW-1:0]                     out_data,
  output logic                                  out_last
);

  localparam int WORD_BW = PARTIAL_SUM_BW * MATRIX_SIZE;
  localparam int IDX_W   = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_SIZE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]                state;
  logic [WORD_BW-1:0]        word_q;
  logic [IDX_W-1:0]          lane_idx;
  logic [ADDRESSSIZE:0]      remaining;
  logic [IDX_W-1:0]          next_idx;
  logic [PARTIAL_SUM_BW-1:0] next_lane;
  logic                      final_word;

  // Widen one lane to the beat width, optionally clamping negatives to zero.
  function automatic logic [OUT_BW-1:0] extend_lane(input logic [PARTIAL_SUM_BW-1:0] v);
`ifdef RESULT_RELU_EN
    if (v[PARTIAL_SUM_BW-1]) return '0;
`endif
    return OUT_BW'($signed(v));
  endfunction

  // Select the lane that follows the one currently on the output.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    next_idx   = '0;
    next_lane  = '0;
    next_idx   = lane_idx + IDX_W'(1);
    next_lane  = word_q[next_idx*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
    final_word = (remaining == (ADDRESSSIZE+1)'(1));
  end

  // Command sequencer: read one word, then hand its lanes out one per handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the word register is a plain flop bank, so it is reset with the rest
      // of the state; reset leaves no stale partial sums behind.
      state        <= S_IDLE;
      word_q       <= '0;
      lane_idx     <= '0;
      remaining    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sram_rd_en   <= 1'b0;
      sram_rd_addr <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side sees the values from before this edge.
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining    <= num_words;
            sram_rd_addr <= base_addr;
            busy         <= 1'b1;
            if (num_words == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              sram_rd_en <= 1'b1;
              state      <= S_READ;
            end
          end
        end
        S_READ: begin
          sram_rd_en <= 1'b0;
          state      <= S_LOAD;
        end
        S_LOAD: begin
          word_q    <= sram_rd_data;
          lane_idx  <= '0;
          out_valid <= 1'b1;
          out_data  <= extend_lane(sram_rd_data[PARTIAL_SUM_BW-1:0]);
          out_last  <= (MATRIX_SIZE == 1) && final_word;
          state     <= S_STREAM;
        end
        S_STREAM: begin
          if (out_ready) begin
            if (lane_idx == LAST_IDX) begin
              out_valid    <= 1'b0;
              out_last     <= 1'b0;
              remaining    <= remaining - (ADDRESSSIZE+1)'(1);
              sram_rd_addr <= sram_rd_addr + ADDRESSSIZE'(1);
              if (final_word) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                sram_rd_en <= 1'b1;
                state      <= S_READ;
              end
            end else begin
              lane_idx <= next_idx;
              out_data <= extend_lane(next_lane);
              out_last <= (next_idx == LAST_IDX) && final_word;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_result_drain.sv
// Directed testbench for tpu_result_drain with a registered-read SRAM model.
module tb_tpu_result_drain;

  localparam int AW = 10;
  localparam int PW = 20;
  localparam int MS = 8;
  localparam int OW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [AW:0]     num_words = '0;
  logic            busy, done, sram_rd_en, out_valid, out_last;
  logic [AW-1:0]   sram_rd_addr;
  logic [PW*MS-1:0] sram_rd_data = '0;
  logic            out_ready = 1'b1;
  logic [OW-1:0]   out_data;

  logic [PW*MS-1:0] mem [1024];

  int checks = 0;
  int errors = 0;

  // Results collected by run_cmd.
  logic [OW-1:0] beat_data [$];
  bit            beat_last [$];
  int            beat_cyc  [$];
  logic [AW-1:0] rd_addr   [$];
  int            rd_cyc    [$];
  int            done_cyc;
  int            done_cnt;
  int            stable_err;
  bit            busy_c1;
  bit            busy_after;

  tpu_result_drain #(.ADDRESSSIZE(AW), .PARTIAL_SUM_BW(PW), .MATRIX_SIZE(MS), .OUT_BW(OW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
    .sram_rd_data(sram_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Registered-read SRAM: data appears the cycle after the read strobe.
  always @(posedge clk) if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];

  task automatic set_word(input int addr, input int v0, input int step);
    logic [PW*MS-1:0] w;
    w = '0;
    for (int k = 0; k < MS; k++) w[k*PW +: PW] = PW'(v0 + k*step);
    mem[addr] = w;
  endtask

  // Issue one command and record everything the DUT does until done (bounded).
  // Cycle numbers are counted from the start edge: cycle 1 is the first cycle after it.
  task automatic run_cmd(input int base, input int num, input int stall_lane, input int stall_cycles);
    int cyc;
    int stall_left;
    bit pv, pr, pl;
    logic [OW-1:0] pd;
    beat_data.delete(); beat_last.delete(); beat_cyc.delete();
    rd_addr.delete(); rd_cyc.delete();
    done_cyc = -1; done_cnt = 0; stable_err = 0; busy_c1 = 0; busy_after = 0;
    stall_left = stall_cycles;
    pv = 0; pr = 1; pl = 0; pd = '0;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(base); num_words = (AW+1)'(num);
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (out_valid && stall_left > 0 && (beat_data.size() % MS) == stall_lane) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) stable_err++;
      if (cyc == 1) busy_c1 = busy;
      if (sram_rd_en) begin rd_addr.push_back(sram_rd_addr); rd_cyc.push_back(cyc); end
      if (out_valid && out_ready) begin
        beat_data.push_back(out_data); beat_last.push_back(out_last); beat_cyc.push_back(cyc);
      end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = busy;
        break;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy, done, sram_rd_en, sram_rd_addr, out_valid, out_data, out_last} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b rd_en=%b addr=%0d valid=%b data=%h last=%b expected all 0",
               busy, done, sram_rd_en, sram_rd_addr, out_valid, out_data, out_last);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sram_rd_en, out_valid, out_last} !== '0) begin
      errors++;
      $display("FAIL idle_outputs got busy=%b done=%b rd_en=%b valid=%b last=%b expected 0",
               busy, done, sram_rd_en, out_valid, out_last);
    end
  endtask

  task automatic test_zero_words;
    run_cmd(3, 0, 0, 0);
    checks++;
    if (done_cyc !== 1) begin errors++; $display("FAIL zero_done_cycle got %0d expected 1", done_cyc); end
    checks++;
    if (busy_c1 !== 1'b1 || busy_after !== 1'b0) begin
      errors++; $display("FAIL zero_busy got c1=%b after=%b expected 1/0", busy_c1, busy_after);
    end
    checks++;
    if (rd_addr.size() != 0 || beat_data.size() != 0) begin
      errors++; $display("FAIL zero_activity got reads=%0d beats=%0d expected 0/0", rd_addr.size(), beat_data.size());
    end
  endtask

  task automatic test_single_word;
    set_word(5, 1, 1);
    run_cmd(5, 1, 0, 0);
    checks++;
    if (rd_addr.size() != 1 || rd_addr[0] !== 10'd5 || rd_cyc[0] != 1) begin
      errors++; $display("FAIL single_read got n=%0d addr=%0d cyc=%0d expected 1/5/1",
                         rd_addr.size(), rd_addr.size() ? rd_addr[0] : 0, rd_cyc.size() ? rd_cyc[0] : -1);
    end
    checks++;
    if (beat_data.size() != 8) begin
      errors++; $display("FAIL single_beat_count got %0d expected 8", beat_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (beat_data[i] !== OW'(i + 1) || beat_cyc[i] != i + 3 || beat_last[i] !== (i == 7)) begin
          errors++;
          $display("FAIL single_beat%0d got data=%h cyc=%0d last=%b expected data=%h cyc=%0d last=%b",
                   i, beat_data[i], beat_cyc[i], beat_last[i], OW'(i + 1), i + 3, (i == 7));
        end
      end
    end
    checks++;
    if (done_cyc != 11 || done_cnt != 1) begin
      errors++; $display("FAIL single_done got cyc=%0d count=%0d expected 11/1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_sign_extend;
    logic [PW*MS-1:0] w;
    logic [OW-1:0] exp_d [MS];
    w = {20'h0000A, 20'hFFFFE, 20'h7FFFF, 20'h12345, 20'hFFFFF, 20'h00000, 20'h00001, 20'h80000};
    mem[9] = w;
`ifdef RESULT_RELU_EN
    exp_d = '{32'h0, 32'h1, 32'h0, 32'h0, 32'h00012345, 32'h0007FFFF, 32'h0, 32'h0000000A};
`else
    exp_d = '{32'hFFF80000, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h00012345, 32'h0007FFFF, 32'hFFFFFFFE, 32'h0000000A};
`endif
    run_cmd(9, 1, 0, 0);
    checks++;
    if (beat_data.size() != MS) begin
      errors++; $display("FAIL sign_beat_count got %0d expected %0d", beat_data.size(), MS);
    end else begin
      for (int i = 0; i < MS; i++) begin
        checks++;
        if (beat_data[i] !== exp_d[i]) begin
          errors++; $display("FAIL sign_lane%0d got %h expected %h", i, beat_data[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    run_cmd(5, 1, 2, 4);
    checks++;
    if (stable_err != 0) begin errors++; $display("FAIL bp_stable got %0d violations expected 0", stable_err); end
    checks++;
    if (beat_data.size() != 8) begin
      errors++; $display("FAIL bp_beat_count got %0d expected 8", beat_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (beat_data[i] !== OW'(i + 1) || beat_last[i] !== (i == 7)) begin
          errors++; $display("FAIL bp_beat%0d got data=%h last=%b expected %h/%b",
                             i, beat_data[i], beat_last[i], OW'(i + 1), (i == 7));
        end
      end
      checks++;
      if (beat_cyc[2] != 9) begin errors++; $display("FAIL bp_lane2_cycle got %0d expected 9", beat_cyc[2]); end
    end
    checks++;
    if (done_cyc != 15) begin errors++; $display("FAIL bp_done_cycle got %0d expected 15", done_cyc); end
  endtask

  task automatic test_wrap;
    set_word(1023, 100, 1);
    set_word(0, 200, 1);
    run_cmd(1023, 2, 0, 0);
    checks++;
    if (rd_addr.size() != 2 || rd_addr[0] !== 10'd1023 || rd_addr[1] !== 10'd0) begin
      errors++; $display("FAIL wrap_reads got n=%0d expected 1023 then 0", rd_addr.size());
    end
    checks++;
    if (beat_data.size() != 16) begin
      errors++; $display("FAIL wrap_beat_count got %0d expected 16", beat_data.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (beat_data[i] !== OW'((i < 8) ? 100 + i : 200 + i - 8) || beat_last[i] !== (i == 15)) begin
          errors++; $display("FAIL wrap_beat%0d got data=%0d last=%b", i, beat_data[i], beat_last[i]);
        end
      end
    end
    checks++;
    if (done_cyc != 21) begin errors++; $display("FAIL wrap_done_cycle got %0d expected 21", done_cyc); end
  endtask

  task automatic test_reset_mid_command;
    int seen_done;
    set_word(12, 30, 1); set_word(13, 40, 1); set_word(14, 50, 1);
    set_word(7, 70, 1);
    seen_done = 0;
    @(negedge clk);
    start = 1'b1; base_addr = 10'd12; num_words = 11'd3;
    @(negedge clk);
    start = 1'b0;
    // Cycle 1 observed; lane 4 of word 0 is on the output during cycle 7.
    repeat (6) @(negedge clk);
    checks++;
    if (!out_valid || out_data !== 32'd34) begin
      errors++; $display("FAIL rstmid_lane4 got valid=%b data=%0d expected 1/34", out_valid, out_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, sram_rd_en, sram_rd_addr, out_valid, out_data, out_last} !== '0) begin
      errors++; $display("FAIL rstmid_immediate got busy=%b valid=%b data=%h addr=%0d expected all 0",
                         busy, out_valid, out_data, sram_rd_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin errors++; $display("FAIL rstmid_no_done got %0d active cycles expected 0", seen_done); end
    run_cmd(7, 1, 0, 0);
    checks++;
    if (beat_data.size() != 8 || beat_data[0] !== 32'd70 || beat_data[7] !== 32'd77 || beat_last[7] !== 1'b1) begin
      errors++; $display("FAIL rstmid_restart_beats got n=%0d", beat_data.size());
    end
    checks++;
    if (done_cyc != 11 || rd_addr.size() != 1 || rd_addr[0] !== 10'd7) begin
      errors++; $display("FAIL rstmid_restart_done got done_cyc=%0d reads=%0d expected 11/1", done_cyc, rd_addr.size());
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = '0;
    test_reset();
    test_zero_words();
    test_single_word();
    test_sign_extend();
    test_backpressure();
    test_wrap();
    test_reset_mid_command();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_result_drain.md
# tpu_result_drain

- Reads accumulated partial-sum rows from the results SRAM and serializes them onto a narrow valid/ready stream toward the host or I/O side, one lane per beat.
- Sits beside the results SRAM as its read-side initiator; the systolic-array path remains the writer.
- A single start command drains a contiguous run of result words beginning at a base address.

## Interface
- ADDRESSSIZE, 10, results SRAM address width
- PARTIAL_SUM_BW, 20, signed width of one partial-sum lane
- MATRIX_SIZE, 8, lanes per SRAM word; SRAM word width = PARTIAL_SUM_BW*MATRIX_SIZE
- OUT_BW, 32, output beat width; must be >= PARTIAL_SUM_BW

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command pulse; sampled only in IDLE
- base_addr  in  ADDRESSSIZE  first word address, latched on accepted start
- num_words  in  ADDRESSSIZE+1  words to drain, latched on accepted start; range 0..2^ADDRESSSIZE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a command completes
- sram_rd_en  out  1  read strobe to results SRAM
- sram_rd_addr  out  ADDRESSSIZE  read address
- sram_rd_data  in  PARTIAL_SUM_BW*MATRIX_SIZE  SRAM read data; valid the cycle after sram_rd_en
- out_valid  out  1  beat valid
- out_ready  in  1  sink ready
- out_data  out  OUT_BW  sign-extended lane value
- out_last  out  1  marks the final beat of the command

## Operation
- States: IDLE, READ, LOAD, STREAM, DONE.
- IDLE: start=1 latches base_addr and num_words.
  - num_words=0 -> go directly to DONE (no SRAM read, no beats).
  - Otherwise -> READ.
  - start is ignored in every other state.
- READ (1 cycle): sram_rd_en=1, sram_rd_addr=current address -> LOAD.
- LOAD (1 cycle): capture sram_rd_data into the word register; lane index=0 -> STREAM.
- STREAM: out_valid=1; out_data = lane[index] sign-extended to OUT_BW.
  - Lane k occupies bits [k*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]; lane 0 is emitted first.
  - Index advances only on out_valid & out_ready.
  - After lane MATRIX_SIZE-1 is accepted: decrement remaining count and increment address (mod 2^ADDRESSSIZE, wraps 1023->0). Remaining>0 -> READ; remaining=0 -> DONE.
- DONE (1 cycle): done=1 -> IDLE.
- out_last = 1 only on lane MATRIX_SIZE-1 of the final word.
- While out_valid & !out_ready, out_data and out_last hold stable.
- out_valid never drops without a handshake.

## Timing
- Reset values: busy=0, done=0, sram_rd_en=0, sram_rd_addr=0, out_valid=0, out_data=0, out_last=0; state=IDLE.
- Outputs are registered.
- start sampled at edge k:
  - READ during cycle k+1.
  - LOAD during k+2.
  - First out_valid during k+3.
- With out_ready held high, each word takes MATRIX_SIZE+2 cycles (8 beats + READ + LOAD bubbles).
- A command of N>0 words with no backpressure: done rises N*(MATRIX_SIZE+2)+1 cycles after the start edge.
- num_words=0: done during cycle k+1; busy high for that cycle only.
- rst asserted mid-command: immediate return to reset values.
  - The partial transfer is abandoned and no done is issued.
  - The first start after rst deasserts is accepted normally.
- A start coincident with DONE is ignored.

## Configuration
- RESULT_RELU_EN defined: each lane is clamped to 0 when negative, before sign extension; out_data is always >= 0.
- RESULT_RELU_EN undefined: lanes are passed as signed values, sign-extended to OUT_BW.
- Control, timing and handshake are identical in both builds.

## Test plan
- Reset then idle: all outputs 0. start with num_words=0 -> done pulse at k+1, no sram_rd_en, no out_valid.
- base_addr=5, num_words=1, word lanes 0..7 = 1,2,..,8, out_ready=1:
  - sram_rd_addr=5 at k+1.
  - Beats 1..8 on k+3..k+10; out_last only on value 8.
  - done at k+11.
- Lane 3 = 20'hFFFFF (-1):
  - Without RESULT_RELU_EN -> out_data=32'hFFFFFFFF.
  - With RESULT_RELU_EN -> 32'h0.
  - Lane value 20'h7FFFF -> 32'h0007FFFF in both builds.
- Backpressure: out_ready low for 4 cycles during lane 2 -> out_data/out_valid stable throughout, no lane skipped or duplicated, done delayed by exactly 4 cycles.
- Wrap: base_addr=1023, num_words=2 -> read addresses 1023 then 0; 16 beats; out_last on beat 16 only.
- rst pulsed during lane 4 of word 0 of a 3-word command:
  - Outputs go to 0 at once; no done.
  - A new start with base_addr=7, num_words=1 then completes normally.
